// File: rtl/serial_alu_pkg.sv
// Shared definitions for the serial ALU: opcodes, status bytes and FSM state encoding.
package serial_alu_pkg;

    localparam logic [7:0] OP_MUL = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_MAC = 8'h02;
    localparam logic [7:0] OP_CLR = 8'h03;

    localparam logic [7:0] ST_ACK = 8'h00;
    localparam logic [7:0] ST_BAD = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        SEND
    } state_e;

endpackage

// File: rtl/serial_alu_if.sv
// Byte stream with stb/rdy handshake.
//   stb : byte valid (driven by master)
//   dat : byte payload (driven by master)
//   rdy : sink accepts byte (driven by slave)
// A byte moves on a rising edge where stb and rdy are both high.
interface serial_alu_if;
    logic       stb;
    logic [7:0] dat;
    logic       rdy;

    modport master (output stb, output dat, input rdy);
    modport slave  (input stb, input dat, output rdy);
endinterface

// File: rtl/serial_alu_mul_iter.sv
// Iterative shift-add unsigned multiplier.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands a/b and begin
//   a, b     : W-bit operands, sampled when start is high
//   done     : one-cycle pulse exactly W cycles after start
//   prod     : 2W-bit product, held until the next start
module serial_alu_mul_iter #(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   prod
);
    localparam int unsigned CW = $clog2(W);

    logic [2*W-1:0] prod_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // The load edge also retires multiplier bit 0, leaving W-1 steps.
                prod_q   <= b[0] ? {{W{1'b0}}, a} : '0;
                mcand_q  <= {{(W-1){1'b0}}, a, 1'b0};
                mplier_q <= b >> 1;
                cnt_q    <= CW'(W - 1);
                run_q    <= 1'b1;
            end else if (run_q) begin
                if (mplier_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: rtl/serial_alu.sv
// Byte-stream arithmetic engine: takes an opcode byte plus two W-bit operands
// (LS byte first), computes MUL/ADD/MAC/CLR and returns the result bytes LS first.
//   clk, rst : clock, synchronous active-high reset
//   s        : input byte stream (slave)
//   m        : output byte stream (master)
//   err      : one-cycle pulse after an invalid opcode is accepted
//   busy     : high whenever the engine is not idle
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int unsigned W              = 8,
    parameter bit          ACC_CLR_ON_RST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    serial_alu_if.slave  s,
    serial_alu_if.master m,
    output logic       err,
    output logic       busy
);
    localparam int unsigned B  = W / 8;
    localparam int unsigned NB = 2 * B;
    localparam int unsigned CW = $clog2(NB);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      op_q;
    logic            one_q;      // single-byte response (CLR / invalid)
    logic [2*W-1:0]  opnd_q;
    logic [2*W-1:0]  opnd_d;
    logic [2*W-1:0]  res_q;      // result bytes still to be sent
    logic [2*W-1:0]  acc_q;
    logic [2*W-1:0]  exec_res;
    logic [2*W-1:0]  prod;
    logic            s_rdy_q;
    logic            m_stb_q;
    logic [7:0]      m_dat_q;
    logic            err_q;
    logic            busy_q;
    logic            s_xfer;
    logic            m_xfer;
    logic            cnt_last;
    logic            mul_start;
    logic            mul_done;

    always_comb begin
        // Operand bytes shift in from the top so byte 0 ends up at bit 0.
        opnd_d    = {s.dat, opnd_q[2*W-1:8]};
        s_xfer    = s.stb && s_rdy_q;
        m_xfer    = m_stb_q && m.rdy;
        cnt_last  = (cnt_q == CW'(NB - 1));
        // Start on the last operand byte so EXEC lasts exactly W cycles.
        mul_start = (state_q == LOAD) && s_xfer && cnt_last && (op_q != OP_ADD);
        if (op_q == OP_ADD) begin
            exec_res = {{W{1'b0}}, opnd_q[W-1:0]} + {{W{1'b0}}, opnd_q[2*W-1:W]};
        end else if (op_q == OP_MAC) begin
            exec_res = acc_q + prod;
        end else begin
            exec_res = prod;
        end
    end

    serial_alu_mul_iter #(
        .W(W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (opnd_d[W-1:0]),
        .b     (opnd_d[2*W-1:W]),
        .done  (mul_done),
        .prod  (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            one_q   <= 1'b0;
            opnd_q  <= '0;
            res_q   <= '0;
            s_rdy_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_dat_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            if (ACC_CLR_ON_RST) begin
                acc_q <= '0;
            end
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    s_rdy_q <= 1'b1;
                    if (s_xfer) begin
                        op_q   <= s.dat;
                        busy_q <= 1'b1;
                        if (s.dat == OP_MUL || s.dat == OP_ADD || s.dat == OP_MAC) begin
                            state_q <= LOAD;
                        end else begin
                            state_q <= SEND;
                            s_rdy_q <= 1'b0;
                            m_stb_q <= 1'b1;
                            one_q   <= 1'b1;
                            if (s.dat == OP_CLR) begin
                                m_dat_q <= ST_ACK;
                                acc_q   <= '0;
                            end else begin
                                m_dat_q <= ST_BAD;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (s_xfer) begin
                        opnd_q <= opnd_d;
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            state_q <= EXEC;
                            s_rdy_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (op_q == OP_ADD || mul_done) begin
                        if (op_q == OP_MAC) begin
                            acc_q <= exec_res;
                        end
                        res_q   <= exec_res >> 8;
                        m_dat_q <= exec_res[7:0];
                        m_stb_q <= 1'b1;
                        one_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (m_xfer) begin
                        if (one_q || cnt_last) begin
                            state_q <= IDLE;
                            m_stb_q <= 1'b0;
                            s_rdy_q <= 1'b1;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            m_dat_q <= res_q[7:0];
                            res_q   <= res_q >> 8;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s.rdy = s_rdy_q;
    assign m.stb = m_stb_q;
    assign m.dat = m_dat_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: one W=8 and one W=16 instance, table-driven
// frames with a byte scoreboard, plus hand sequences for backpressure and reset.
module tb_serial_alu;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       sel     = 1'b0;   // 0: W=8 instance, 1: W=16 instance
    logic       drv_stb = 1'b0;
    logic [7:0] drv_dat = 8'h00;
    logic       m_rdy   = 1'b1;
    logic       err8, busy8, err16, busy16;
    logic       mon_stb, mon_s_rdy, mon_err, mon_busy;
    logic [7:0] mon_dat;

    serial_alu_if s8_if ();
    serial_alu_if m8_if ();
    serial_alu_if s16_if ();
    serial_alu_if m16_if ();

    assign s8_if.stb  = drv_stb & ~sel;
    assign s8_if.dat  = drv_dat;
    assign m8_if.rdy  = m_rdy;
    assign s16_if.stb = drv_stb & sel;
    assign s16_if.dat = drv_dat;
    assign m16_if.rdy = m_rdy;

    assign mon_stb   = sel ? m16_if.stb : m8_if.stb;
    assign mon_dat   = sel ? m16_if.dat : m8_if.dat;
    assign mon_s_rdy = sel ? s16_if.rdy : s8_if.rdy;
    assign mon_err   = sel ? err16 : err8;
    assign mon_busy  = sel ? busy16 : busy8;

    serial_alu #(.W(8)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .s    (s8_if),
        .m    (m8_if),
        .err  (err8),
        .busy (busy8)
    );

    serial_alu #(.W(16)) u_dut16 (
        .clk  (clk),
        .rst  (rst),
        .s    (s16_if),
        .m    (m16_if),
        .err  (err16),
        .busy (busy16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] ins;
        int          n_in;
        logic [31:0] outs;
        int          n_out;
        int          lat;
        int          errs;
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_in_cyc = 0;
    int first_stb_cyc = -1;
    int first_out_cyc = -1;
    int last_out_cyc = 0;
    int err_cnt = 0;
    int out_cnt = 0;
    logic s_xfer_seen = 1'b0;
    logic hold_chk = 1'b0;
    logic [7:0] hold_dat = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Observe the upcoming edge from the preceding falling edge.
    task automatic sample();
        s_xfer_seen = drv_stb && mon_s_rdy;
        if (s_xfer_seen) last_in_cyc = cyc;
        if (mon_err) err_cnt++;
        if (mon_stb && first_stb_cyc < 0) first_stb_cyc = cyc;
        if (hold_chk && !rst) check("hold_stable", {mon_stb, mon_dat}, {1'b1, hold_dat});
        hold_chk = mon_stb && !m_rdy && !rst;
        hold_dat = mon_dat;
        if (mon_stb && m_rdy && !rst) begin
            check("out_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("out_byte", mon_dat, exp_q.pop_front());
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            out_cnt++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        drv_stb = 1'b1;
        drv_dat = b;
        do begin
            step();
            n++;
        end while (!s_xfer_seen && n < 100);
        drv_stb = 1'b0;
        check("in_accept", s_xfer_seen, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
            step();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        check("idle_busy", mon_busy, 0);
        check("idle_s_rdy", mon_s_rdy, 1);
        check("idle_gap", cyc - last_out_cyc, 1);
    endtask

    task automatic run_frame(input logic [39:0] ins, input int n_in, input logic [31:0] outs,
                             input int n_out, input int lat, input int errs);
        int e0;
        first_stb_cyc = -1;
        first_out_cyc = -1;
        e0 = err_cnt;
        for (int j = 0; j < n_out; j++) exp_q.push_back(outs[8*j +: 8]);
        for (int i = 0; i < n_in; i++) send_byte(ins[8*i +: 8]);
        drain();
        check("latency", first_stb_cyc - last_in_cyc, lat);
        check("burst", last_out_cyc - first_out_cyc, n_out - 1);
        check("err_pulses", err_cnt - e0, errs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int out0;
        // ins: bytes LS first; outs: expected bytes LS first
        vecs[0]  = '{40'h0B0C00, 3, 32'h0084, 2, 9, 0};   // MUL 12*11
        vecs[1]  = '{40'h02FF01, 3, 32'h0101, 2, 2, 0};   // ADD with carry
        vecs[2]  = '{40'h03,     1, 32'h00,   1, 1, 0};   // CLR
        vecs[3]  = '{40'h040302, 3, 32'h000C, 2, 9, 0};   // MAC -> 000C
        vecs[4]  = '{40'hFFFF02, 3, 32'hFE0D, 2, 9, 0};   // MAC -> FE0D
        vecs[5]  = '{40'hFFFF02, 3, 32'hFC0E, 2, 9, 0};   // MAC wraps -> FC0E
        vecs[6]  = '{40'h7E,     1, 32'hFF,   1, 1, 1};   // invalid opcode
        vecs[7]  = '{40'h030200, 3, 32'h0006, 2, 9, 0};   // MUL right after invalid
        vecs[8]  = '{40'h808001, 3, 32'h0100, 2, 2, 0};   // ADD 80+80
        vecs[9]  = '{40'hFFFF00, 3, 32'hFE01, 2, 9, 0};   // MUL FF*FF
        vecs[10] = '{40'h04,     1, 32'hFF,   1, 1, 1};   // invalid opcode
        vecs[11] = '{40'h010102, 3, 32'hFC0F, 2, 9, 0};   // MAC keeps acc FC0E

        @(posedge clk);
        #1;
        repeat (3) step();
        check("rst_outs8", {s8_if.rdy, m8_if.stb, m8_if.dat, err8, busy8}, 0);
        check("rst_outs16", {s16_if.rdy, m16_if.stb, m16_if.dat, err16, busy16}, 0);
        rst = 1'b0;
        check("rst_rel_rdy_low", mon_s_rdy, 0);
        step();
        check("rst_rel_rdy8", s8_if.rdy, 1);
        check("rst_rel_rdy16", s16_if.rdy, 1);

        for (int v = 0; v < 12; v++) begin
            run_frame(vecs[v].ins, vecs[v].n_in, vecs[v].outs, vecs[v].n_out,
                      vecs[v].lat, vecs[v].errs);
        end

        // Backpressure: output held 5 cycles; junk on s_stb must be ignored.
        first_stb_cyc = -1;
        first_out_cyc = -1;
        exp_q.push_back(8'h84);
        exp_q.push_back(8'h00);
        m_rdy = 1'b0;
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h0B);
        begin
            int n = 0;
            while (!mon_stb && n < 50) begin
                step();
                n++;
            end
        end
        drv_stb = 1'b1;
        drv_dat = 8'h55;
        repeat (5) begin
            step();
            check("bp_hold", {mon_stb, mon_dat, mon_s_rdy}, {1'b1, 8'h84, 1'b0});
        end
        drv_stb = 1'b0;
        m_rdy   = 1'b1;
        drain();
        check("bp_latency", first_stb_cyc - last_in_cyc, 9);
        check("bp_burst", last_out_cyc - first_out_cyc, 1);
        run_frame(40'h03, 1, 32'h00, 1, 1, 0);

        // W=16: reset after 2 of 4 operand bytes discards the frame.
        sel = 1'b1;
        send_byte(8'h00);
        send_byte(8'h34);
        send_byte(8'h12);
        check("mid_busy", mon_busy, 1);
        rst = 1'b1;
        step();
        step();
        check("mid_rst_busy", mon_busy, 0);
        rst = 1'b0;
        check("mid_rst_rdy_low", mon_s_rdy, 0);
        out0 = out_cnt;
        step();
        check("mid_rst_rdy", mon_s_rdy, 1);
        repeat (12) step();
        check("mid_rst_no_out", out_cnt - out0, 0);
        run_frame(40'hFFFFFFFF00, 5, 32'hFFFE0001, 4, 17, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
